// File: rtl/stack_ctrl.sv
// stack_ctrl: multi-cycle PUSH/POP/CALL/RTS engine for the MiniRISC full-descending stack.
// Define STACK_GUARD_EN to enable the overflow/underflow guard (ERR state, err pulse).
module stack_ctrl #(
  parameter logic [3:0] SP_ADDR     = 4'hF,
  parameter logic [7:0] STACK_EMPTY = 8'h00,
  parameter logic [7:0] STACK_FULL  = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [7:0] push_data,
  input  logic [7:0] pc_in,
  input  logic [3:0] dst_addr,
  input  logic [7:0] sp_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] pc_out,
  output logic       pc_load,
  output logic       rf_wr_en,
  output logic [3:0] rf_wr_addr,
  output logic [7:0] rf_wr_data,
  output logic [7:0] dm_addr,
  output logic       dm_wr,
  output logic       dm_rd,
  output logic [7:0] dm_wdata,
  input  logic [7:0] dm_rdata
);

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RTS  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE, S_MWR, S_MRD, S_CAP, S_RFW, S_SPW, S_DONE
`ifdef STACK_GUARD_EN
    , S_ERR
`endif
  } state_t;

  state_t     state, state_nxt;
  op_t        op_q;
  logic [7:0] sp_q, data_q, cap_q;
  logic [3:0] dst_q;
  logic [7:0] sp_dec, sp_inc;
  logic       op_is_pop;

  assign sp_dec    = sp_q - 8'd1;
  assign sp_inc    = sp_q + 8'd1;
  assign op_is_pop = (op_q == OP_POP) || (op_q == OP_RTS);

`ifdef STACK_GUARD_EN
  // Pop-type ops have op[0] set; push-type ops have it clear.
  logic guard_hit;
  assign guard_hit = (!op[0] && (sp_in == STACK_FULL)) || (op[0] && (sp_in == STACK_EMPTY));
`else
  logic unused_guard_params;
  assign unused_guard_params = ^{STACK_FULL, STACK_EMPTY};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_PUSH;
      sp_q   <= '0;
      data_q <= '0;
      dst_q  <= '0;
      cap_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req) begin
        op_q   <= op_t'(op);
        sp_q   <= sp_in;
        data_q <= (op_t'(op) == OP_CALL) ? pc_in : push_data;
        dst_q  <= dst_addr;
      end
      if (state == S_CAP) cap_q <= dm_rdata;
    end
  end

  // Outputs decode from the state register only, so an asynchronous reset
  // silences every strobe the moment it asserts.
  always_comb begin
    // NOTE: every output and next-state gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    pc_out     = '0;
    pc_load    = 1'b0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    dm_addr    = '0;
    dm_wr      = 1'b0;
    dm_rd      = 1'b0;
    dm_wdata   = '0;

    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = op[0] ? S_MRD : S_MWR;
`ifdef STACK_GUARD_EN
          if (guard_hit) state_nxt = S_ERR;
`endif
        end
      end
      S_MWR: begin
        busy      = 1'b1;
        dm_wr     = 1'b1;
        dm_addr   = sp_dec;
        dm_wdata  = data_q;
        state_nxt = S_SPW;
      end
      S_MRD: begin
        busy      = 1'b1;
        dm_rd     = 1'b1;
        dm_addr   = sp_q;
        state_nxt = S_CAP;
      end
      S_CAP: begin
        busy      = 1'b1;
        state_nxt = S_RFW;
      end
      S_RFW: begin
        busy = 1'b1;
        if (op_q == OP_RTS) begin
          pc_load = 1'b1;
          pc_out  = cap_q;
        end else begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = dst_q;
          rf_wr_data = cap_q;
        end
        state_nxt = S_SPW;
      end
      S_SPW: begin
        // Written after RFW, so a POP into SP still ends with the adjusted SP.
        busy       = 1'b1;
        rf_wr_en   = 1'b1;
        rf_wr_addr = SP_ADDR;
        rf_wr_data = op_is_pop ? sp_inc : sp_dec;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
`ifdef STACK_GUARD_EN
      S_ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
